alex_spi_tx: RTL
================

// Module: alex_spi_tx
// PURPOSE
//  Serialiser downstream of the Alex band decoder. Packs HPF select, LPF select, attenuator
//  and RX-out relay bits into one 16-bit control word and shifts it to the Alex board over a
//  3-wire SPI link (SPI_data, SPI_clock, SPI_load). Sends after reset, on any word change,
//  and optionally at a periodic refresh interval.
// PARAMETERS
//  CLK_DIV  4  clocks per SPI_clock half-period (>=2)
//  REFRESH  0  clocks between forced resends measured from end of last frame; 0 disables
// PORTS
//  clock      in   1  system clock
//  reset_n    in   1  asynchronous, active-low reset
//  HPF        in   6  one-hot HPF select from band decoder
//  LPF        in   7  one-hot LPF select
//  atten      in   2  attenuator bits {20dB,10dB}
//  rx_out     in   1  RX-out relay
//  SPI_data   out  1  serial data, MSB first
//  SPI_clock  out  1  serial clock; idle low, slave samples on rising edge
//  SPI_load   out  1  latch strobe, high for CLK_DIV clocks after bit 0
//  busy       out  1  high from capture to end of GAP
// BEHAVIOUR
//  - Interface: one clock; reset is asynchronous and active-low.
//  - Word = {rx_out, atten[1:0], LPF[6:0], HPF[5:0]} (bit 15..0). Inputs registered into
//    word_r every clock (1-cycle latency).
//  - Reset: SPI_data=0, SPI_clock=0, SPI_load=0, busy=0, state=IDLE, last_sent=0,
//    force=1, bit count=0, divider=0, refresh count=0.
//  - States: IDLE -> LOW -> HIGH -> (LOW | STROBE) -> GAP -> IDLE.
//  - IDLE: if force | (word_r!=last_sent) | refresh expired: shreg<=word_r,
//    last_sent<=word_r, force<=0, clear refresh count, busy<=1, go LOW.
//  - LOW: SPI_clock=0, SPI_data=shreg[15]; hold CLK_DIV clocks, go HIGH.
//  - HIGH: SPI_clock=1, data stable; hold CLK_DIV clocks; then shreg<<=1, count++;
//    count==16 -> STROBE else LOW.
//  - STROBE: SPI_clock=0, SPI_data=0, SPI_load=1 for CLK_DIV clocks, go GAP.
//  - GAP: all SPI lines low for CLK_DIV clocks; busy drops on leaving GAP.
//  - Frame length from capture to IDLE = (32+2)*CLK_DIV clocks exactly.
//  - Latency: input change at edge N -> capture at edge N+2 (if IDLE) -> first SPI_data
//    valid after edge N+2.
//  - Input change mid-frame: frame in flight completes unmodified with captured word; next
//    IDLE sees mismatch and sends new word immediately (no gap beyond GAP state).
//  - Multiple changes mid-frame: only latest word_r is sent; intermediate words dropped.
//  - Refresh counter runs only in IDLE; saturates at REFRESH; change + refresh same cycle
//    -> single frame.
//  - reset_n asserted mid-frame: all outputs low next instant; post-reset frame resends.
//  - Outputs registered; no combinational path from inputs to SPI pins.
// STRUCTURE
//  - Shared package alex_pkg: ALEX_WORD_W=16, field LSB positions
//    (HPF_LSB=0, LPF_LSB=6, ATT_LSB=13, RXOUT_BIT=15), state encoding localparams.
//  - Sub-module alex_spi_tick: CLK_DIV half-period counter producing a one-clock tick;
//    cleared on state entry. FSM, shift register, refresh counter live in top.
// TESTING (CLK_DIV=4 unless stated)
//  - Reset release, inputs HPF=6'b100000 others 0 -> one frame, slave model captures
//    16'h0020, frame 136 clocks, SPI_load high 4 clocks.
//  - Static inputs 10000 clocks, REFRESH=0 -> exactly one frame, busy low thereafter.
//  - HPF 6'b010000->6'b000001 at bit 5 of frame -> first frame 16'h0010, second
//    16'h0001 starting right after GAP.
//  - Three changes during one frame, last word 16'hA041 -> exactly two frames total,
//    second carries 16'hA041.
//  - REFRESH=1000 -> frames start every 1000+136 clocks with identical word.
//  - reset_n low at bit 8 -> pins low immediately, no SPI_load; after release, full frame
//    of current word.

Source files
------------

// File: rtl/alex_pkg.sv
// Shared definitions for the Alex control-word serialiser: word layout,
// FSM state encoding and the field packing helper.
package alex_pkg;

  localparam int ALEX_WORD_W = 16;
  localparam int HPF_LSB     = 0;
  localparam int LPF_LSB     = 6;
  localparam int ATT_LSB     = 13;
  localparam int RXOUT_BIT   = 15;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOW    = 3'd1,
    ST_HIGH   = 3'd2,
    ST_STROBE = 3'd3,
    ST_GAP    = 3'd4
  } alex_state_t;

  function automatic logic [ALEX_WORD_W-1:0] alexPackWord(
    input logic [5:0] hpf,
    input logic [6:0] lpf,
    input logic [1:0] att,
    input logic       rx
  );
    logic [ALEX_WORD_W-1:0] word;
    word                 = '0;
    word[HPF_LSB +: 6]   = hpf;
    word[LPF_LSB +: 7]   = lpf;
    word[ATT_LSB +: 2]   = att;
    word[RXOUT_BIT]      = rx;
    return word;
  endfunction

endpackage

// File: rtl/alex_spi_tick.sv
// Half-period timer: pulses o_tick on the last clock of every CLK_DIV-clock
// interval and restarts whenever the owning FSM changes state.
module alex_spi_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_clear,
  output logic o_tick
);

  localparam int             CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt <= '0;
    end else if (i_clear || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/alex_spi_tx.sv
// Alex board control-word serialiser: registers the band-decoder outputs and
// shifts the 16-bit word out over SPI_data/SPI_clock/SPI_load when it changes.
module alex_spi_tx
  import alex_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int REFRESH = 0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [5:0] HPF,
  input  logic [6:0] LPF,
  input  logic [1:0] atten,
  input  logic       rx_out,
  output logic       SPI_data,
  output logic       SPI_clock,
  output logic       SPI_load,
  output logic       busy
);

  localparam logic [31:0] REFRESH_LAST = (REFRESH > 0) ? 32'(REFRESH - 1) : 32'd0;

  logic [ALEX_WORD_W-1:0] r_word;
  logic [ALEX_WORD_W-1:0] r_lastSent;
  logic [ALEX_WORD_W-1:0] r_shreg;
  logic                   r_force;
  logic [4:0]             r_bitCnt;
  logic [31:0]            r_refreshCnt;
  alex_state_t            r_state;
  alex_state_t            w_stateNext;
  logic                   w_tick;
  logic                   w_clear;
  logic                   w_refreshDue;
  logic                   w_send;

  // Deliberately not reset, so the first post-reset frame carries live inputs.
  always_ff @(posedge clock) begin
    r_word <= alexPackWord(HPF, LPF, atten, rx_out);
  end

  assign w_refreshDue = (REFRESH != 0) && (r_refreshCnt == REFRESH_LAST);
  assign w_send       = r_force || (r_word != r_lastSent) || w_refreshDue;
  assign w_clear      = (w_stateNext != r_state);

  alex_spi_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .i_clock   (clock),
    .i_reset_n (reset_n),
    .i_clear   (w_clear),
    .o_tick    (w_tick)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE:   if (w_send) w_stateNext = ST_LOW;
      ST_LOW:    if (w_tick) w_stateNext = ST_HIGH;
      ST_HIGH:   if (w_tick) w_stateNext = (r_bitCnt == 5'd15) ? ST_STROBE : ST_LOW;
      ST_STROBE: if (w_tick) w_stateNext = ST_GAP;
      ST_GAP:    if (w_tick) w_stateNext = ST_IDLE;
      default:   w_stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_lastSent   <= '0;
      r_shreg      <= '0;
      r_force      <= 1'b1;
      r_bitCnt     <= '0;
      r_refreshCnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_send) begin
            r_shreg      <= r_word;
            r_lastSent   <= r_word;
            r_force      <= 1'b0;
            r_bitCnt     <= '0;
            r_refreshCnt <= '0;
          end else if (r_refreshCnt != REFRESH_LAST) begin
            r_refreshCnt <= r_refreshCnt + 32'd1;
          end
        end
        ST_HIGH: begin
          if (w_tick) begin
            r_shreg  <= {r_shreg[ALEX_WORD_W-2:0], 1'b0};
            r_bitCnt <= r_bitCnt + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Pins decode only from registered state, so nothing from the inputs reaches them.
  always_comb begin
    SPI_clock = (r_state == ST_HIGH);
    SPI_data  = ((r_state == ST_LOW) || (r_state == ST_HIGH)) ? r_shreg[ALEX_WORD_W-1] : 1'b0;
    SPI_load  = (r_state == ST_STROBE);
    busy      = (r_state != ST_IDLE);
  end

endmodule
